// File: rtl/encoder_pkg.sv
// Shared types and helpers for the rotary encoder front end.
// AB pairs are packed as {B,A}, matching i_key_in[1:0].
package encoder_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
  } dir_t;

  localparam logic [1:0] REST_AB = 2'b11;

  // Single-step quadrature direction; double changes decode as DIR_NONE.
  function automatic dir_t quad_step(input logic [1:0] prev_ab, input logic [1:0] next_ab);
    dir_t dir;
    case ({prev_ab, next_ab})
      4'b11_01, 4'b01_00, 4'b00_10, 4'b10_11: dir = DIR_CW;
      4'b01_11, 4'b00_01, 4'b10_00, 4'b11_10: dir = DIR_CCW;
      default:                                dir = DIR_NONE;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-FF synchroniser plus per-bit stability counter for active-low pins.
// Everything resets to the idle (all ones) level so reset release is glitch-free.
module key_debounce #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned DEB_CNT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable
);

  localparam int unsigned CNT_W = $clog2(DEB_CNT + 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // A bit is accepted once its counter has saturated and the mismatch persists.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEB_CNT)) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= i_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign o_stable = stable_q;

endmodule

// File: rtl/encoder_quad_decoder.sv
// Rotary encoder front end: debounce, quadrature decode and detent accumulation.
// Emits single-cycle enter / clockwise / counter-clockwise pulses.
module encoder_quad_decoder #(
  parameter int unsigned CLK_FRE          = 50_000_000,
  parameter int unsigned DEBOUNCE_US      = 2000,
  parameter int unsigned STEPS_PER_DETENT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_key_in,
  output logic       o_enter,
  output logic       o_roate,
  output logic       o_roate_r,
  output logic [1:0] o_ab_level
);

  import encoder_pkg::*;

  localparam int unsigned       DEB_CNT  = CLK_FRE / 1_000_000 * DEBOUNCE_US;
  localparam logic signed [3:0] STEP_POS = 4'(STEPS_PER_DETENT);
  localparam logic signed [3:0] STEP_NEG = -STEP_POS;

  logic [2:0]        stable;
  logic [1:0]        ab_prev_q;
  logic              enter_prev_q;
  logic signed [3:0] acc_q, acc_d, sum;
  logic              roate_q, roate_d;
  logic              roate_r_q, roate_r_d;
  logic              enter_q, enter_d;
  dir_t              dir;

  key_debounce #(
    .WIDTH   (3),
    .DEB_CNT (DEB_CNT)
  ) u_debounce (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_raw    (i_key_in),
    .o_stable (stable)
  );

  // Step accumulation on each debounced AB change; invalid jumps leave acc alone.
  always_comb begin
    acc_d     = acc_q;
    roate_d   = 1'b0;
    roate_r_d = 1'b0;
    enter_d   = enter_prev_q & ~stable[2];
    dir       = DIR_NONE;
    sum       = acc_q;
    if (stable[1:0] != ab_prev_q) begin
      dir = quad_step(ab_prev_q, stable[1:0]);
      case (dir)
        DIR_CW:  sum = acc_q + 4'sd1;
        DIR_CCW: sum = acc_q - 4'sd1;
        default: sum = acc_q;
      endcase
      if (dir != DIR_NONE) begin
        if (sum == STEP_POS) begin
          roate_d = 1'b1;
          acc_d   = '0;
        end else if (sum == STEP_NEG) begin
          roate_r_d = 1'b1;
          acc_d     = '0;
        end else if (STEPS_PER_DETENT == 4 && stable[1:0] == REST_AB) begin
          acc_d = '0;
        end else begin
          acc_d = sum;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ab_prev_q    <= REST_AB;
      enter_prev_q <= 1'b1;
      acc_q        <= '0;
      roate_q      <= 1'b0;
      roate_r_q    <= 1'b0;
      enter_q      <= 1'b0;
    end else begin
      ab_prev_q    <= stable[1:0];
      enter_prev_q <= stable[2];
      acc_q        <= acc_d;
      roate_q      <= roate_d;
      roate_r_q    <= roate_r_d;
      enter_q      <= enter_d;
    end
  end

  assign o_enter    = enter_q;
  assign o_roate    = roate_q;
  assign o_roate_r  = roate_r_q;
  assign o_ab_level = stable[1:0];

endmodule

// File: tb/tb_encoder_quad_decoder.sv
// Directed + randomized bench for encoder_quad_decoder with a level-sequence reference model.
module tb_encoder_quad_decoder;

  localparam int DEB = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] key;
  logic       enter, rot, rotr;
  logic [1:0] ab_lvl;

  encoder_quad_decoder #(
    .CLK_FRE          (1_000_000),
    .DEBOUNCE_US      (4),
    .STEPS_PER_DETENT (4)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_key_in   (key),
    .o_enter    (enter),
    .o_roate    (rot),
    .o_roate_r  (rotr),
    .o_ab_level (ab_lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // Driven pin levels and expected debounced state / accumulator.
  logic p_a, p_b, p_en;
  logic m_a, m_b, m_en;
  int   m_acc;
  logic [1:0] seq [4] = '{2'b11, 2'b10, 2'b00, 2'b01};  // CW order, {A,B}

  function automatic int pos(input logic a, input logic b);
    for (int i = 0; i < 4; i++) if (seq[i] == {a, b}) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    key = {p_en, p_b, p_a};
  endtask

  task automatic quiet(input logic [1:0] exp_ab);
    @(negedge clk);
    chk("ab_level_quiet", ab_lvl, exp_ab);
    chk("o_roate_quiet", {1'b0, rot}, 2'b00);
    chk("o_roate_r_quiet", {1'b0, rotr}, 2'b00);
    chk("o_enter_quiet", {1'b0, enter}, 2'b00);
  endtask

  // Pins have just changed (or reset just released); predict and check the response.
  task automatic window(input int hold);
    logic oa, ob, oen, ecw, eccw, een;
    int d;
    oa = m_a; ob = m_b; oen = m_en;
    ecw = 1'b0; eccw = 1'b0;
    een = oen && !p_en;
    if ({p_a, p_b} != {oa, ob}) begin
      d = (pos(p_a, p_b) - pos(oa, ob) + 4) % 4;
      if (d == 1 || d == 3) begin
        m_acc += (d == 1) ? 1 : -1;
        if (m_acc == 4) begin ecw = 1'b1; m_acc = 0; end
        else if (m_acc == -4) begin eccw = 1'b1; m_acc = 0; end
        else if ({p_a, p_b} == 2'b11) m_acc = 0;
      end
    end
    for (int j = 0; j < hold; j++) begin
      @(negedge clk);
      chk("ab_level", ab_lvl, (j >= DEB + 2) ? {p_b, p_a} : {ob, oa});
      chk("o_roate", {1'b0, rot}, {1'b0, ecw && j == DEB + 3});
      chk("o_roate_r", {1'b0, rotr}, {1'b0, eccw && j == DEB + 3});
      chk("o_enter", {1'b0, enter}, {1'b0, een && j == DEB + 3});
    end
    m_a = p_a; m_b = p_b; m_en = p_en;
  endtask

  task automatic step(input logic a, input logic b, input logic en, input int hold);
    p_a = a; p_b = b; p_en = en;
    drive();
    window(hold);
  endtask

  task automatic cw_cycle();
    step(1'b1, 1'b0, p_en, 20);
    step(1'b0, 1'b0, p_en, 20);
    step(1'b0, 1'b1, p_en, 20);
    step(1'b1, 1'b1, p_en, 20);
  endtask

  // Short glitches on one pin that always return to the accepted level.
  task automatic bounce(input int which, input int n, input int gmin, input int gmax);
    int g, r;
    for (int i = 0; i < n; i++) begin
      g = int'($urandom_range(gmax, gmin));
      r = int'($urandom_range(gmax, gmin));
      case (which)
        0: p_a = ~p_a;
        1: p_b = ~p_b;
        default: p_en = ~p_en;
      endcase
      drive();
      repeat (g) quiet({m_b, m_a});
      p_a = m_a; p_b = m_b; p_en = m_en;
      drive();
      repeat (r) quiet({m_b, m_a});
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    m_a = 1'b1; m_b = 1'b1; m_en = 1'b1; m_acc = 0;
    repeat (cycles) quiet(2'b11);
    rst_n = 1'b1;
    window(20);
  endtask

  initial begin
    int r, idx, dir_sign, hold;
    logic [1:0] nab;
    p_a = 1'b1; p_b = 1'b1; p_en = 1'b1;
    drive();
    do_reset(3);

    // Full clockwise and counter-clockwise detents
    cw_cycle();
    step(1'b0, 1'b1, 1'b1, 20);
    step(1'b0, 1'b0, 1'b1, 20);
    step(1'b1, 1'b0, 1'b1, 20);
    step(1'b1, 1'b1, 1'b1, 20);

    // Chatter on A, then settle low
    bounce(0, 7, 2, 2);
    step(1'b0, 1'b1, 1'b1, 20);
    step(1'b1, 1'b1, 1'b1, 20);

    // Aborted partial turn, then a full one
    step(1'b1, 1'b0, 1'b1, 20);
    step(1'b0, 1'b0, 1'b1, 20);
    step(1'b1, 1'b0, 1'b1, 20);
    step(1'b1, 1'b1, 1'b1, 20);
    cw_cycle();

    // Invalid double change
    step(1'b0, 1'b0, 1'b1, 20);
    step(1'b1, 1'b1, 1'b1, 20);

    // Enter press/hold/release, then enter coinciding with the final CW step
    step(1'b1, 1'b1, 1'b0, 100);
    step(1'b1, 1'b1, 1'b1, 20);
    step(1'b1, 1'b0, 1'b1, 20);
    step(1'b0, 1'b0, 1'b1, 20);
    step(1'b0, 1'b1, 1'b1, 20);
    step(1'b1, 1'b1, 1'b0, 20);
    step(1'b1, 1'b1, 1'b1, 20);

    // Reset after two CW steps discards the partial turn
    step(1'b1, 1'b0, 1'b1, 20);
    step(1'b0, 1'b0, 1'b1, 20);
    do_reset(4);
    step(1'b0, 1'b1, 1'b1, 20);
    step(1'b1, 1'b1, 1'b1, 20);
    cw_cycle();

    // Randomized walk with runs in one direction, glitches and enter activity
    dir_sign = 1;
    for (int it = 0; it < 200; it++) begin
      r = int'($urandom_range(9, 0));
      hold = int'($urandom_range(16, 8));
      if ($urandom_range(7, 0) == 0) dir_sign = -dir_sign;
      idx = pos(m_a, m_b);
      nab = seq[(idx + 4 + dir_sign) % 4];
      case (r)
        6: begin
          nab = seq[(idx + 2) % 4];
          step(nab[1], nab[0], m_en, hold);
        end
        7: step(m_a, m_b, ~m_en, hold);
        8: step(nab[1], nab[0], ~m_en, hold);
        9: begin
          bounce(int'($urandom_range(2, 0)), int'($urandom_range(3, 1)), 1, DEB);
          step(nab[1], nab[0], m_en, hold);
        end
        default: step(nab[1], nab[0], m_en, hold);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
